// File: rtl/tag_lookup_sequencer_fa_pkg.sv
// Shared encodings for the fully-associative tag lookup sequencer.
// Holds the op codes, the FSM states and a clog2 helper.
package tag_lookup_sequencer_fa_pkg;

    typedef enum logic [1:0] {
        TSEQ_OP_LOOKUP = 2'b00,
        TSEQ_OP_FILL   = 2'b01,
        TSEQ_OP_INVAL  = 2'b10,
        TSEQ_OP_RSVD   = 2'b11
    } tseq_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_EVICT  = 3'd2,
        S_WRITE  = 3'd3,
        S_INVAL  = 3'd4,
        S_RESP   = 3'd5
    } tseq_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tag_lookup_sequencer_fa_free_slot_encoder.sv
// Shadow valid vector -> {any_free, lowest free index}.
// Purely combinational priority encoder.
module free_slot_encoder #(
    parameter int N  = 16,
    parameter int BW = 4
) (
    input  logic [N-1:0]  valid,
    output logic          any_free,
    output logic [BW-1:0] idx
);

    always_comb begin
        any_free = 1'b0;
        idx      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                any_free = 1'b1;
                idx      = BW'(i);
            end
        end
    end

endmodule

// File: rtl/tag_lookup_sequencer_fa.sv
// Request sequencer for the fully-associative tag lookup table.
// Optional counters: define TAG_SEQ_STATS_EN.
module tag_lookup_sequencer_fa
    import tag_lookup_sequencer_fa_pkg::*;
#(
    parameter int BW_ADDR_SPACE        = 24,
    parameter int CACHE_BLOCK_CAPACITY = 16,
    parameter int WORDS_PER_BLOCK      = 4,
    localparam int BW_CACHE_ADDR = clog2(CACHE_BLOCK_CAPACITY),
    localparam int BW_TAG = BW_ADDR_SPACE - clog2(WORDS_PER_BLOCK)
) (
    input  logic                     clock_i,
    input  logic                     resetn_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_op_i,
    input  logic [BW_TAG-1:0]        req_tag_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic                     rsp_hit_o,
    output logic [BW_CACHE_ADDR-1:0] rsp_addr_o,
    output logic                     rsp_evict_o,
    output logic [BW_TAG-1:0]        rsp_evict_tag_o,
    output logic [BW_TAG-1:0]        lut_tag_search_o,
    output logic [BW_TAG-1:0]        lut_tag_write_o,
    output logic [BW_CACHE_ADDR-1:0] lut_addr_o,
    output logic                     lut_wren_o,
    output logic                     lut_rmen_o,
    input  logic                     lut_hit_i,
    input  logic [BW_CACHE_ADDR-1:0] lut_addr_i,
    input  logic [BW_TAG-1:0]        lut_tag_i
`ifdef TAG_SEQ_STATS_EN
    ,
    input  logic                     stat_clear_i,
    output logic [31:0]              stat_hits_o,
    output logic [31:0]              stat_misses_o,
    output logic [31:0]              stat_evicts_o
`endif
);

    localparam int CAP = CACHE_BLOCK_CAPACITY;
    localparam logic [BW_CACHE_ADDR-1:0] RR_LAST =
        BW_CACHE_ADDR'(CAP - 1);

    tseq_state_e state_q, state_d;
    logic [1:0]               op_q;
    logic [BW_TAG-1:0]        tag_q;
    logic [BW_CACHE_ADDR-1:0] addr_q;
    logic [BW_CACHE_ADDR-1:0] rr_q;
    logic                     hit_q;
    logic                     evict_q;
    logic [BW_TAG-1:0]        evict_tag_q;
    logic [CAP-1:0]           valid_q;
    logic                     any_free;
    logic [BW_CACHE_ADDR-1:0] free_idx;

    free_slot_encoder #(
        .N  (CAP),
        .BW (BW_CACHE_ADDR)
    ) u_free (
        .valid    (valid_q),
        .any_free (any_free),
        .idx      (free_idx)
    );

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (req_valid_i) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (lut_hit_i)
                    state_d = (op_q == TSEQ_OP_INVAL) ? S_INVAL : S_RESP;
                else if (op_q == TSEQ_OP_FILL)
                    state_d = any_free ? S_WRITE : S_EVICT;
                else
                    state_d = S_RESP;
            end
            S_EVICT:  state_d = S_WRITE;
            S_WRITE:  state_d = S_RESP;
            S_INVAL:  state_d = S_RESP;
            S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            op_q        <= '0;
            tag_q       <= '0;
            addr_q      <= '0;
            rr_q        <= '0;
            hit_q       <= 1'b0;
            evict_q     <= 1'b0;
            evict_tag_q <= '0;
            valid_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (req_valid_i) begin
                    op_q  <= req_op_i;
                    tag_q <= req_tag_i;
                end
                S_LOOKUP: begin
                    hit_q       <= lut_hit_i;
                    evict_q     <= 1'b0;
                    evict_tag_q <= '0;
                    if (lut_hit_i)
                        addr_q <= lut_addr_i;
                    else if (op_q == TSEQ_OP_FILL)
                        addr_q <= any_free ? free_idx : rr_q;
                    else
                        addr_q <= '0;
                end
                S_EVICT: begin
                    evict_q     <= 1'b1;
                    evict_tag_q <= lut_tag_i;
                    rr_q <= (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
                end
                S_WRITE: valid_q[addr_q] <= 1'b1;
                S_INVAL: valid_q[addr_q] <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready_o      = 1'b0;
        rsp_valid_o      = 1'b0;
        rsp_hit_o        = 1'b0;
        rsp_addr_o       = '0;
        rsp_evict_o      = 1'b0;
        rsp_evict_tag_o  = '0;
        lut_tag_search_o = '0;
        lut_tag_write_o  = '0;
        lut_addr_o       = '0;
        lut_wren_o       = 1'b0;
        lut_rmen_o       = 1'b0;
        unique case (state_q)
            S_IDLE:   req_ready_o = resetn_i;
            S_LOOKUP: lut_tag_search_o = tag_q;
            S_EVICT:  lut_addr_o = addr_q;
            S_WRITE: begin
                lut_wren_o      = 1'b1;
                lut_addr_o      = addr_q;
                lut_tag_write_o = tag_q;
            end
            S_INVAL: begin
                lut_rmen_o = 1'b1;
                lut_addr_o = addr_q;
            end
            S_RESP: begin
                rsp_valid_o     = 1'b1;
                rsp_hit_o       = hit_q;
                rsp_addr_o      = addr_q;
                rsp_evict_o     = evict_q;
                rsp_evict_tag_o = evict_tag_q;
            end
            default: ;
        endcase
    end

`ifdef TAG_SEQ_STATS_EN
    logic resp_entry;
    logic entry_hit;

    assign resp_entry = (state_q != S_RESP) && (state_d == S_RESP);
    // Coming straight from LOOKUP, hit_q has not been written yet
    assign entry_hit = (state_q == S_LOOKUP) ? lut_hit_i : hit_q;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            stat_hits_o   <= '0;
            stat_misses_o <= '0;
            stat_evicts_o <= '0;
        end else if (stat_clear_i) begin
            stat_hits_o   <= '0;
            stat_misses_o <= '0;
            stat_evicts_o <= '0;
        end else if (resp_entry) begin
            if (entry_hit && stat_hits_o != '1)
                stat_hits_o <= stat_hits_o + 1'b1;
            if (!entry_hit && stat_misses_o != '1)
                stat_misses_o <= stat_misses_o + 1'b1;
            if (evict_q && stat_evicts_o != '1)
                stat_evicts_o <= stat_evicts_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tag_lookup_sequencer_fa.sv
// Scoreboard bench for tag_lookup_sequencer_fa with a 4-entry table model.
// Stats checks are compiled in when TAG_SEQ_STATS_EN is defined.
module tb_tag_lookup_sequencer_fa;

    localparam logic [1:0] OP_LK = 2'b00;
    localparam logic [1:0] OP_FL = 2'b01;
    localparam logic [1:0] OP_IV = 2'b10;
    localparam logic [1:0] OP_RS = 2'b11;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [21:0] req_tag;
    logic        rsp_valid, rsp_ready, rsp_hit, rsp_evict;
    logic [1:0]  rsp_addr;
    logic [21:0] rsp_evict_tag;
    logic [21:0] lut_tag_search, lut_tag_write, lut_tag_in;
    logic [1:0]  lut_addr, lut_addr_in;
    logic        lut_wren, lut_rmen, lut_hit;
`ifdef TAG_SEQ_STATS_EN
    logic        stat_clear;
    logic [31:0] stat_hits, stat_misses, stat_evicts;
    int          e_hits, e_misses, e_evicts;
`endif

    always #5 clk = ~clk;

    tag_lookup_sequencer_fa #(
        .BW_ADDR_SPACE        (24),
        .CACHE_BLOCK_CAPACITY (4),
        .WORDS_PER_BLOCK      (4)
    ) dut (
        .clock_i          (clk),
        .resetn_i         (resetn),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_op_i         (req_op),
        .req_tag_i        (req_tag),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_hit_o        (rsp_hit),
        .rsp_addr_o       (rsp_addr),
        .rsp_evict_o      (rsp_evict),
        .rsp_evict_tag_o  (rsp_evict_tag),
        .lut_tag_search_o (lut_tag_search),
        .lut_tag_write_o  (lut_tag_write),
        .lut_addr_o       (lut_addr),
        .lut_wren_o       (lut_wren),
        .lut_rmen_o       (lut_rmen),
        .lut_hit_i        (lut_hit),
        .lut_addr_i       (lut_addr_in),
        .lut_tag_i        (lut_tag_in)
`ifdef TAG_SEQ_STATS_EN
        ,
        .stat_clear_i     (stat_clear),
        .stat_hits_o      (stat_hits),
        .stat_misses_o    (stat_misses),
        .stat_evicts_o    (stat_evicts)
`endif
    );

    // Behavioural fully-associative table
    logic [21:0] t_tag [4];
    logic        t_vld [4];

    always_comb begin
        lut_hit     = 1'b0;
        lut_addr_in = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (t_vld[i] && t_tag[i] == lut_tag_search) begin
                lut_hit     = 1'b1;
                lut_addr_in = 2'(i);
            end
        end
        lut_tag_in = t_tag[lut_addr];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                t_vld[i] <= 1'b0;
                t_tag[i] <= '0;
            end
        end else if (lut_wren) begin
            t_tag[lut_addr] <= lut_tag_write;
            t_vld[lut_addr] <= 1'b1;
        end else if (lut_rmen) begin
            t_vld[lut_addr] <= 1'b0;
        end
    end

    typedef struct {
        logic        hit;
        logic [1:0]  addr;
        logic        ev;
        logic [21:0] etag;
        int          lat;
        int          nwr;
        int          nrm;
    } exp_t;

    exp_t        sbq[$];
    logic [21:0] m_tag [4];
    logic        m_vld [4];
    logic [1:0]  m_rr;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_evict,
                rsp_evict_tag, lut_tag_search, lut_tag_write,
                lut_addr, lut_wren, lut_rmen};
    endfunction

    function automatic logic [127:0] rsp_bus();
        return {rsp_valid, rsp_hit, rsp_addr, rsp_evict,
                rsp_evict_tag, req_ready};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_vld[i] = 1'b0;
            m_tag[i] = '0;
        end
        m_rr = 2'd0;
        sbq.delete();
    endtask

    task automatic predict(input logic [1:0] op, input logic [21:0] tag);
        exp_t e;
        int   idx, fr;
        idx = -1;
        fr  = -1;
        for (int i = 3; i >= 0; i--) begin
            if (m_vld[i] && m_tag[i] == tag) idx = i;
            if (!m_vld[i]) fr = i;
        end
        e = '{hit: 1'b0, addr: 2'd0, ev: 1'b0, etag: '0,
              lat: 2, nwr: 0, nrm: 0};
        if (idx >= 0) begin
            e.hit  = 1'b1;
            e.addr = 2'(idx);
            if (op == OP_IV) begin
                e.lat = 3;
                e.nrm = 1;
                m_vld[idx] = 1'b0;
            end
        end else if (op == OP_FL) begin
            e.nwr = 1;
            if (fr >= 0) begin
                e.addr = 2'(fr);
                e.lat  = 3;
            end else begin
                e.addr = m_rr;
                e.ev   = 1'b1;
                e.etag = m_tag[m_rr];
                e.lat  = 4;
                m_rr   = m_rr + 2'd1;
            end
            m_tag[e.addr] = tag;
            m_vld[e.addr] = 1'b1;
        end
        sbq.push_back(e);
    endtask

    task automatic run_req(input logic [1:0] op, input logic [21:0] tag,
                           input int hold);
        exp_t         e;
        int           n, lat, nwr, nrm;
        logic [127:0] snap;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_tag   = tag;
        predict(op, tag);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_tag   = '0;
        lat = 0;
        nwr = 0;
        nrm = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lut_wren) nwr++;
            if (lut_rmen) nrm++;
            chk("wr_rm_excl", lut_wren & lut_rmen, 0);
        end while (!rsp_valid && lat < 12);
        e = sbq.pop_front();
        chk("rsp_valid", rsp_valid, 1);
        chk("latency", lat, e.lat);
        chk("hit", rsp_hit, e.hit);
        chk("addr", rsp_addr, e.addr);
        chk("evict", rsp_evict, e.ev);
        chk("evict_tag", rsp_evict_tag, e.etag);
        chk("wren_cnt", nwr, e.nwr);
        chk("rmen_cnt", nrm, e.nrm);
        chk("req_ready_busy", req_ready, 0);
`ifdef TAG_SEQ_STATS_EN
        if (e.hit) e_hits++;
        else       e_misses++;
        if (e.ev)  e_evicts++;
`endif
        snap = rsp_bus();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_stable", rsp_bus(), snap);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic reset_in_evict(input logic [21:0] tag);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_op    = OP_FL;
        req_tag   = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_tag   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("evict_addr", lut_addr, m_rr);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_outs", all_outs(), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_wren", lut_wren, 0);
            chk("rst_outs_hold", all_outs(), 0);
        end
        resetn = 1'b1;
        model_reset();
`ifdef TAG_SEQ_STATS_EN
        e_hits   = 0;
        e_misses = 0;
        e_evicts = 0;
`endif
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_tag   = '0;
        rsp_ready = 1'b0;
`ifdef TAG_SEQ_STATS_EN
        stat_clear = 1'b0;
        e_hits     = 0;
        e_misses   = 0;
        e_evicts   = 0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_out_of_rst", req_ready, 1);

        for (int i = 0; i < 4; i++) run_req(OP_FL, 22'h10 + 22'(i), 0);
        run_req(OP_LK, 22'h12, 0);
        run_req(OP_LK, 22'h99, 0);
        run_req(OP_FL, 22'h20, 0);
        run_req(OP_FL, 22'h21, 0);
        run_req(OP_IV, 22'h12, 0);
        run_req(OP_IV, 22'h12, 0);
        run_req(OP_FL, 22'h30, 0);
        run_req(OP_FL, 22'h13, 0);
        run_req(OP_RS, 22'h21, 0);
        for (int i = 0; i < 4; i++)
            run_req(OP_FL, 22'h22 + 22'(i), (i == 0) ? 5 : 0);
        run_req(OP_LK, 22'h25, 0);

`ifdef TAG_SEQ_STATS_EN
        @(negedge clk);
        chk("stat_hits", stat_hits, e_hits);
        chk("stat_misses", stat_misses, e_misses);
        chk("stat_evicts", stat_evicts, e_evicts);
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        chk("stat_clr", {stat_hits, stat_misses, stat_evicts}, 0);
        e_hits   = 0;
        e_misses = 0;
        e_evicts = 0;
`endif

        reset_in_evict(22'h50);
        run_req(OP_FL, 22'h40, 0);
        run_req(OP_LK, 22'h40, 0);

`ifdef TAG_SEQ_STATS_EN
        @(negedge clk);
        chk("stat_hits_post", stat_hits, e_hits);
        chk("stat_misses_post", stat_misses, e_misses);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
